// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared states, opcodes, funct3 names and ALU codes for the control unit
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_DECODE     = 3'd1,
    ST_EXECUTE    = 3'd2,
    ST_MEMORY     = 3'd3,
    ST_WRITE_BACK = 3'd4,
    ST_TRAP       = 3'd5
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_STYPE = 7'b0100011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // alt selects SUB over ADD and SRA over SRL
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - combinational instruction classifier: ALU op, operand select, legality, branch sense
module mc_alu_decode
  import mc_ctrl_pkg::*;
#(
  parameter int EN_BRANCH_EXT = 1
) (
  input  logic [31:0] i_ir,
  output logic [3:0]  o_alu_ctrl,
  output logic        o_alu_src,
  output logic        o_legal,
  output logic        o_is_branch,
  output logic        o_br_invert
);

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_ext_ok;
  logic       w_unused_ir_bits;

  assign w_opcode         = i_ir[6:0];
  assign w_f3             = i_ir[14:12];
  assign w_f7             = i_ir[31:25];
  assign w_ext_ok         = (EN_BRANCH_EXT != 0);
  assign w_unused_ir_bits = ^{i_ir[24:15], i_ir[11:7]};

  always_comb begin
    o_alu_ctrl  = ALU_ADD;
    o_alu_src   = 1'b0;
    o_legal     = 1'b0;
    o_is_branch = 1'b0;
    o_br_invert = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        o_alu_ctrl = alu_from_f3(w_f3, w_f7[5]);
        o_legal    = (w_f7 == F7_BASE) ||
                     ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SR)));
      end
      OP_ITYPE: begin
        o_alu_src  = 1'b1;
        o_alu_ctrl = alu_from_f3(w_f3, (w_f3 == F3_SR) && i_ir[30]);
        case (w_f3)
          F3_SLL:  o_legal = (w_f7 == F7_BASE);
          F3_SR:   o_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
          default: o_legal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        o_alu_src = 1'b1;
        o_legal   = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
      end
      OP_STYPE: begin
        o_alu_src = 1'b1;
        o_legal   = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
      end
      OP_BTYPE: begin
        o_is_branch = 1'b1;
        // taken = Zero ^ br_invert once the compare op has run
        case (w_f3)
          F3_BEQ:  begin o_alu_ctrl = ALU_SUB;  o_br_invert = 1'b0; o_legal = 1'b1;     end
          F3_BNE:  begin o_alu_ctrl = ALU_SUB;  o_br_invert = 1'b1; o_legal = w_ext_ok; end
          F3_BLT:  begin o_alu_ctrl = ALU_SLT;  o_br_invert = 1'b1; o_legal = w_ext_ok; end
          F3_BGE:  begin o_alu_ctrl = ALU_SLT;  o_br_invert = 1'b0; o_legal = w_ext_ok; end
          F3_BLTU: begin o_alu_ctrl = ALU_SLTU; o_br_invert = 1'b1; o_legal = w_ext_ok; end
          F3_BGEU: begin o_alu_ctrl = ALU_SLTU; o_br_invert = 1'b0; o_legal = w_ext_ok; end
          default: o_legal = 1'b0;
        endcase
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle RV32I control FSM with memory wait-states, timeout and illegal-instr trap
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int CNT_W         = 32,
  parameter int EN_BRANCH_EXT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             iReady,
  input  logic             dReady,
  input  logic             Zero,
  output logic             PCSrc,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             loadPC,
  output logic [3:0]       ALUCtrl,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IllegalInstr,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] RetiredCnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_ir;
  logic              r_taken;
  logic [WAIT_W-1:0] r_wait;
  logic              r_illegal;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_retired;

  logic [3:0] w_alu_ctrl;
  logic       w_alu_src;
  logic       w_legal;
  logic       w_is_branch;
  logic       w_br_invert;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_writes_reg;
  logic       w_mem_expired;

  mc_alu_decode #(
    .EN_BRANCH_EXT(EN_BRANCH_EXT)
  ) u_alu_decode (
    .i_ir        (r_ir),
    .o_alu_ctrl  (w_alu_ctrl),
    .o_alu_src   (w_alu_src),
    .o_legal     (w_legal),
    .o_is_branch (w_is_branch),
    .o_br_invert (w_br_invert)
  );

  assign w_is_load     = (r_ir[6:0] == OP_LOAD);
  assign w_is_store    = (r_ir[6:0] == OP_STYPE);
  assign w_writes_reg  = (r_ir[6:0] == OP_RTYPE) || (r_ir[6:0] == OP_ITYPE) || w_is_load;
  // dReady on the final counted cycle still completes the access
  assign w_mem_expired = !dReady && (r_wait == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_ir      <= '0;
      r_taken   <= 1'b0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_FETCH && iReady)
        r_ir <= instr;
      if (r_state == ST_EXECUTE)
        r_taken <= Zero ^ w_br_invert;
      r_wait <= (r_state == ST_MEMORY) ? r_wait + WAIT_W'(1) : '0;
      if (r_state == ST_DECODE && !w_legal)
        r_illegal <= 1'b1;
      if (r_state == ST_MEMORY && w_mem_expired)
        r_timeout <= 1'b1;
      if (r_state == ST_WRITE_BACK)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH:      if (iReady) w_state_nxt = ST_DECODE;
      ST_DECODE:     w_state_nxt = w_legal ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE:    w_state_nxt = (w_is_load || w_is_store) ? ST_MEMORY : ST_WRITE_BACK;
      ST_MEMORY: begin
        if (dReady)
          w_state_nxt = ST_WRITE_BACK;
        else if (w_mem_expired)
          w_state_nxt = ST_TRAP;
      end
      ST_WRITE_BACK: w_state_nxt = ST_FETCH;
      ST_TRAP:       w_state_nxt = ST_TRAP;
      default:       w_state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    loadPC   = 1'b0;
    ALUCtrl  = 4'b0000;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    case (r_state)
      ST_EXECUTE: begin
        ALUSrc  = w_alu_src;
        ALUCtrl = w_alu_ctrl;
      end
      ST_MEMORY: begin
        ALUSrc   = w_alu_src;
        ALUCtrl  = w_alu_ctrl;
        MemRead  = w_is_load;
        MemWrite = w_is_store;
      end
      ST_WRITE_BACK: begin
        ALUSrc   = w_alu_src;
        ALUCtrl  = w_alu_ctrl;
        loadPC   = 1'b1;
        PCSrc    = w_is_branch && r_taken;
        RegWrite = w_writes_reg;
        MemToReg = w_is_load;
      end
      default: ;
    endcase
  end

  assign IllegalInstr = r_illegal;
  assign MemTimeout   = r_timeout;
  assign RetiredCnt   = r_retired;

endmodule
